// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared op encoding, FSM states and default timeout for the mult/div sequencer
package multdiv_pkg;
  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV = 1'b1;
  localparam int TIMEOUT_DEF = 40;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM = 2'd1,
    S_START = 2'd2,
    S_WAIT = 2'd3
  } state_t;
endpackage

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences one MULT/DIV request through the iterative units and writes HI/LO
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_is_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        mult_start,
  input  logic        mult_done,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic        div_start,
  input  logic        div_done,
  input  logic        div_by_zero,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        div0_exc,
  output logic        timeout_err
);
  state_t r_state, w_next;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic [CNT_W-1:0] r_cnt;
  logic r_is_div, r_mult_start, r_div_start, r_div0, r_tout;
  logic w_accept, w_zero, w_qual, w_dbz, w_done, w_tout, w_wr, w_div0, w_tout_p;
  assign w_accept = op_valid && r_state == S_IDLE;
  assign w_zero = op_is_div == MD_DIV && op_b == 32'd0;
  assign w_qual = r_cnt != '0;
  assign w_dbz = w_qual && r_is_div == MD_DIV && div_by_zero;
  assign w_done = w_qual && (r_is_div == MD_DIV ? div_done : mult_done);
  assign w_tout = r_cnt == CNT_W'(TIMEOUT);
  // next state and one-cycle event decode; divide-by-zero beats done, done beats timeout
  always_comb begin
    w_next = r_state;
    w_wr = 1'b0;
    w_div0 = 1'b0;
    w_tout_p = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_div0 = w_zero;
        w_next = w_zero ? S_IDLE : S_ARM;
      end
      S_ARM: w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT: if (w_dbz) begin
        w_div0 = 1'b1;
        w_next = S_IDLE;
      end else if (w_done) begin
        w_wr = 1'b1;
        w_next = S_IDLE;
      end else if (w_tout) begin
        w_tout_p = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
  // state, operand latch, wait counter, registered pulses and HI/LO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_a <= '0;
      r_b <= '0;
      r_is_div <= MD_MULT;
      r_cnt <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_mult_start <= 1'b0;
      r_div_start <= 1'b0;
      r_div0 <= 1'b0;
      r_tout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a <= op_a;
        r_b <= op_b;
        r_is_div <= op_is_div;
      end
      r_cnt <= r_state == S_START ? '0 : r_state == S_WAIT ? r_cnt + 1'b1 : r_cnt;
      r_mult_start <= r_state == S_ARM && r_is_div == MD_MULT;
      r_div_start <= r_state == S_ARM && r_is_div == MD_DIV;
      r_div0 <= w_div0;
      r_tout <= w_tout_p;
      if (w_wr) begin
        r_hi <= r_is_div == MD_DIV ? div_rem : mult_hi;
        r_lo <= r_is_div == MD_DIV ? div_quot : mult_lo;
      end
    end
  end
  assign op_ready = r_state == S_IDLE;
  assign busy = r_state != S_IDLE;
  assign unit_a = r_a;
  assign unit_b = r_b;
  assign mult_start = r_mult_start;
  assign div_start = r_div_start;
  assign hi = r_hi;
  assign lo = r_lo;
  assign div0_exc = r_div0;
  assign timeout_err = r_tout;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: randomized self-checking bench with stub units and a cycle-level reference model
module tb_multdiv_ctrl;
  logic clk = 1'b0, reset_n = 1'b0;
  logic op_valid = 1'b0, op_is_div = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic op_ready, mult_start, div_start, busy, div0_exc, timeout_err;
  logic [31:0] unit_a, unit_b, mult_hi, mult_lo, div_quot, div_rem, hi, lo;
  logic mult_done = 1'b0, div_done = 1'b0, div_by_zero = 1'b0, ovr = 1'b0;
  logic [31:0] s_mhi = 32'h1234_5678, s_mlo = 32'h9ABC_DEF0, s_q = 32'hDEAD_BEEF, s_r = 32'hCAFE_F00D;
  logic [31:0] m_hi = '0, m_lo = '0;
  int checks = 0, errors = 0;

  multdiv_ctrl #(.TIMEOUT(40), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_is_div(op_is_div), .op_a(op_a), .op_b(op_b), .unit_a(unit_a), .unit_b(unit_b),
    .mult_start(mult_start), .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_start(div_start), .div_done(div_done), .div_by_zero(div_by_zero),
    .div_quot(div_quot), .div_rem(div_rem), .hi(hi), .lo(lo), .busy(busy),
    .div0_exc(div0_exc), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // stub units compute their results from the latched operands on their start pulse
  always @(posedge clk) begin
    if (mult_start) {s_mhi, s_mlo} <= 64'(unit_a) * 64'(unit_b);
    if (div_start) begin
      s_q <= unit_a / unit_b;
      s_r <= unit_a % unit_b;
    end
  end
  assign mult_hi = ovr ? 32'hAAAA_AAAA : s_mhi;
  assign mult_lo = ovr ? 32'h5555_5555 : s_mlo;
  assign div_quot = s_q;
  assign div_rem = s_r;

  function automatic logic [63:0] ref_res(input bit d, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return d ? {a % b, a / b} : p;
  endfunction

  // mode: 0 done after n cycles, 1 unit hangs, 2 divider flags zero, 3 stale done held first
  task automatic do_op(input bit d, input logic [31:0] a, input logic [31:0] b, input int n,
                       input int mode, input bit noise);
    int fin;
    logic [63:0] e;
    logic sd, oth;
    fin = (mode == 1) ? 44 : 3 + n;
    e = {m_hi, m_lo};
    if (mode == 0 || mode == 3) e = (!d && ovr) ? 64'hAAAA_AAAA_5555_5555 : ref_res(d, a, b);
    op_valid = 1'b1; op_is_div = d; op_a = a; op_b = b;
    div_done = d && mode == 3; mult_done = !d && mode == 3; div_by_zero = 1'b0;
    for (int k = 1; k <= fin; k++) begin
      @(negedge clk);
      checks++;
      if ({op_ready, busy} !== {1'(k == fin), 1'(k != fin)}) begin
        errors++; $display("FAIL ready_busy k=%0d got %b exp %b", k, {op_ready, busy}, {1'(k == fin), 1'(k != fin)});
      end
      checks++;
      if ({mult_start, div_start} !== {1'(k == 2 && !d), 1'(k == 2 && d)}) begin
        errors++; $display("FAIL starts k=%0d got %b exp %b", k, {mult_start, div_start}, {1'(k == 2 && !d), 1'(k == 2 && d)});
      end
      checks++;
      if ({div0_exc, timeout_err} !== {1'(mode == 2 && k == fin), 1'(mode == 1 && k == fin)}) begin
        errors++; $display("FAIL pulses k=%0d got %b exp %b", k, {div0_exc, timeout_err}, {1'(mode == 2 && k == fin), 1'(mode == 1 && k == fin)});
      end
      checks++;
      if ({unit_a, unit_b} !== {a, b}) begin
        errors++; $display("FAIL operands k=%0d got %h exp %h", k, {unit_a, unit_b}, {a, b});
      end
      checks++;
      if ({hi, lo} !== (k == fin ? e : {m_hi, m_lo})) begin
        errors++; $display("FAIL hilo k=%0d got %h exp %h", k, {hi, lo}, (k == fin ? e : {m_hi, m_lo}));
      end
      op_valid = mode == 1 && k == 10;
      op_is_div = ~d; op_a = ~a; op_b = b ^ 32'h1;
      sd = (mode == 3 && k <= 3) || ((mode == 0 || mode == 3) && k == 2 + n);
      oth = noise ? 1'($urandom % 2) : 1'b0;
      div_done = d ? sd : oth;
      mult_done = d ? oth : sd;
      div_by_zero = d && mode == 2 && k == 2 + n;
    end
    op_valid = 1'b0; div_done = 1'b0; mult_done = 1'b0; div_by_zero = 1'b0;
    {m_hi, m_lo} = e;
  endtask

  task automatic do_div0(input logic [31:0] a);
    op_valid = 1'b1; op_is_div = 1'b1; op_a = a; op_b = 32'd0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if ({div0_exc, timeout_err, busy, op_ready} !== {1'(k == 1), 3'b001}) begin
        errors++; $display("FAIL div0_flags k=%0d got %b exp %b", k, {div0_exc, timeout_err, busy, op_ready}, {1'(k == 1), 3'b001});
      end
      checks++;
      if ({mult_start, div_start} !== 2'b00) begin
        errors++; $display("FAIL div0_start k=%0d got %b exp 00", k, {mult_start, div_start});
      end
      checks++;
      if ({hi, lo, unit_a} !== {m_hi, m_lo, a}) begin
        errors++; $display("FAIL div0_hold k=%0d got %h exp %h", k, {hi, lo, unit_a}, {m_hi, m_lo, a});
      end
      op_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({op_ready, busy, mult_start, div_start, div0_exc, timeout_err} !== 6'b100000) begin
      errors++; $display("FAIL reset_ctl got %b exp 100000", {op_ready, busy, mult_start, div_start, div0_exc, timeout_err});
    end
    checks++;
    if ({hi, lo, unit_a, unit_b} !== 128'd0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {hi, lo, unit_a, unit_b});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({op_ready, busy} !== 2'b10) begin
      errors++; $display("FAIL idle_after_reset got %b exp 10", {op_ready, busy});
    end
  endtask

  task automatic test_div();
    do_op(1'b1, 32'd100, 32'd7, 33, 0, 1'b0);
    checks++;
    if ({hi, lo} !== {32'd2, 32'd14}) begin
      errors++; $display("FAIL div100_7 got %h exp %h", {hi, lo}, {32'd2, 32'd14});
    end
  endtask

  task automatic test_div0();
    ovr = 1'b1;
    do_op(1'b0, 32'd3, 32'd5, 4, 0, 1'b0);
    ovr = 1'b0;
    do_div0(32'd5);
    checks++;
    if ({hi, lo} !== 64'hAAAA_AAAA_5555_5555) begin
      errors++; $display("FAIL div0_preload got %h exp aaaaaaaa55555555", {hi, lo});
    end
  endtask

  task automatic test_mult();
    do_op(1'b0, 32'hFFFF_FFFF, 32'd2, 32, 0, 1'b0);
    checks++;
    if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) begin
      errors++; $display("FAIL mult_max got %h exp 00000001fffffffe", {hi, lo});
    end
    do_op(1'b0, 32'hDEAD_0001, 32'h0001_0003, 2, 0, 1'b1);
  endtask

  task automatic test_stale();
    do_op(1'b1, 32'd1000, 32'd33, 10, 3, 1'b0);
    do_op(1'b0, 32'd65537, 32'd65535, 10, 3, 1'b0);
  endtask

  task automatic test_timeout();
    do_op(1'b0, 32'd11, 32'd13, 0, 1, 1'b0);
    do_op(1'b1, 32'd99, 32'd4, 0, 1, 1'b1);
    do_op(1'b1, 32'hFFFF_FFFF, 32'd10, 41, 0, 1'b0);
    do_op(1'b1, 32'd77, 32'd7, 5, 2, 1'b0);
  endtask

  task automatic test_async_reset();
    op_valid = 1'b1; op_is_div = 1'b1; op_a = 32'd50; op_b = 32'd5;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      op_valid = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({op_ready, busy, mult_start, div_start, div0_exc, timeout_err} !== 6'b100000) begin
      errors++; $display("FAIL async_ctl got %b exp 100000", {op_ready, busy, mult_start, div_start, div0_exc, timeout_err});
    end
    checks++;
    if ({hi, lo, unit_a, unit_b} !== 128'd0) begin
      errors++; $display("FAIL async_data got %h exp 0", {hi, lo, unit_a, unit_b});
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_hi = '0; m_lo = '0;
    do_op(1'b1, 32'd9, 32'd3, 5, 0, 1'b0);
    checks++;
    if ({hi, lo} !== {32'd0, 32'd3}) begin
      errors++; $display("FAIL div9_3 got %h exp %h", {hi, lo}, {32'd0, 32'd3});
    end
  endtask

  task automatic test_random();
    bit d;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      d = 1'($urandom % 2);
      a = $urandom;
      b = ($urandom % 2) ? $urandom : $urandom_range(0, 15);
      if (d && b == 0) do_div0(a);
      else do_op(d, a, b, $urandom_range(2, 41), 0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_div();
    test_div0();
    test_mult();
    test_stale();
    test_timeout();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
